// File: rtl/up_ctrl_unit.sv
// ----------------------------------------------------------------------------
// up_ctrl_unit
//
// Purpose:
//   Moore control unit for an 8-bit accumulator machine. The datapath has
//   IR/A/PC registers, a 32x8 RAM and an add/sub ALU. The unit runs
//   FETCH -> DECODE -> EXECUTE for the 3-bit opcode in IR[7:5] and drives
//   every datapath control strobe. JZ and JPOS branch on the datapath flags.
//   IN can wait for an operator handshake. HALT is sticky until reset.
//   A retired-instruction counter is provided for debug.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter (wraps modulo 2^CNT_W)
//   IN_HSHAKE  1: IN waits for a rising edge on Enter; 0: IN completes at once
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ir[2:0]      opcode, IR[7:5]
//   i_aeq0         A == 0
//   i_apos         A[7] == 0
//   i_enter        operator strobe for IN (asynchronous level)
//   o_irload       load IR from RAM output
//   o_jmpmux       PC source: 1 = PC+1, 0 = IR[4:0]
//   o_pcload       load PC
//   o_meminst      RAM address: 1 = IR[4:0], 0 = PC
//   o_memwr        RAM write strobe (writes A)
//   o_aload        load A
//   o_sub          ALU: 1 = A - M, 0 = A + M
//   o_asel[1:0]    A source: 1x = RAM, 01 = input, 00 = ALU
//   o_halt         high while halted
//   o_state[3:0]   current state code (debug)
//   o_instr_cnt    instructions retired since reset
// ----------------------------------------------------------------------------
module up_ctrl_unit #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          IN_HSHAKE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_ir,
  input  logic             i_aeq0,
  input  logic             i_apos,
  input  logic             i_enter,
  output logic             o_irload,
  output logic             o_jmpmux,
  output logic             o_pcload,
  output logic             o_meminst,
  output logic             o_memwr,
  output logic             o_aload,
  output logic             o_sub,
  output logic [1:0]       o_asel,
  output logic             o_halt,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_instr_cnt
);

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd8,
    StStore  = 4'd9,
    StAdd    = 4'd10,
    StSub    = 4'd11,
    StIn     = 4'd12,
    StJz     = 4'd13,
    StJpos   = 4'd14,
    StHalt   = 4'd15
  } state_e;

  // State and counter registers
  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;

  // Enter synchroniser (s1, s2) plus the previous synchronised value (s3)
  logic r_enter_s1;
  logic r_enter_s2;
  logic r_enter_s3;
  logic w_edge_now;
  logic w_edge_next;

  // Registered strobes and their next-state values
  logic       r_irload,  w_irload_d;
  logic       r_jmpmux,  w_jmpmux_d;
  logic       r_pcload,  w_pcload_d;
  logic       r_meminst, w_meminst_d;
  logic       r_memwr,   w_memwr_d;
  logic       r_aload,   w_aload_d;
  logic       r_sub,     w_sub_d;
  logic [1:0] r_asel,    w_asel_d;
  logic       r_halt,    w_halt_d;

  // Rising edge seen by the synchroniser in the current cycle.
  assign w_edge_now  = r_enter_s2 & ~r_enter_s3;
  // The edge that will be visible next cycle; used to pre-compute the
  // registered Aload so it lines up with the cycle the edge is consumed.
  assign w_edge_next = r_enter_s1 & ~r_enter_s2;

  // Next-state logic
  always_comb begin
    w_state_d = StStart;
    case (r_state)
      StStart:  w_state_d = StFetch;
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        case (i_ir)
          3'b000:  w_state_d = StLoad;
          3'b001:  w_state_d = StStore;
          3'b010:  w_state_d = StAdd;
          3'b011:  w_state_d = StSub;
          3'b100:  w_state_d = StIn;
          3'b101:  w_state_d = StJz;
          3'b110:  w_state_d = StJpos;
          default: w_state_d = StHalt;
        endcase
      end
      StLoad, StStore, StAdd, StSub, StJz, StJpos: w_state_d = StFetch;
      StIn: begin
        if (!IN_HSHAKE || w_edge_now) begin
          w_state_d = StFetch;
        end else begin
          w_state_d = StIn;
        end
      end
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StStart;  // unused codes recover through START
    endcase
  end

  // An instruction retires when its execute state hands back to FETCH,
  // or when DECODE commits to HALT (HALT itself never leaves).
  always_comb begin
    w_cnt_inc = 1'b0;
    if ((r_state inside {StLoad, StStore, StAdd, StSub, StIn, StJz, StJpos}) &&
        (w_state_d == StFetch)) begin
      w_cnt_inc = 1'b1;
    end
    if ((r_state == StDecode) && (w_state_d == StHalt)) begin
      w_cnt_inc = 1'b1;
    end
  end

  // Strobes for the upcoming state, registered so outputs are glitch-free.
  // The branch flags are taken during DECODE; A is not loaded in DECODE, so
  // they equal the flags seen during the JZ/JPOS cycle.
  always_comb begin
    w_irload_d  = 1'b0;
    w_jmpmux_d  = 1'b0;
    w_pcload_d  = 1'b0;
    w_meminst_d = 1'b0;
    w_memwr_d   = 1'b0;
    w_aload_d   = 1'b0;
    w_sub_d     = 1'b0;
    w_asel_d    = 2'b00;
    w_halt_d    = 1'b0;
    case (w_state_d)
      StFetch: begin
        w_irload_d = 1'b1;
        w_pcload_d = 1'b1;
        w_jmpmux_d = 1'b1;
      end
      StDecode: w_meminst_d = 1'b1;
      StLoad: begin
        w_meminst_d = 1'b1;
        w_asel_d    = 2'b10;
        w_aload_d   = 1'b1;
      end
      StStore: begin
        w_meminst_d = 1'b1;
        w_memwr_d   = 1'b1;
      end
      StAdd: begin
        w_meminst_d = 1'b1;
        w_aload_d   = 1'b1;
      end
      StSub: begin
        w_meminst_d = 1'b1;
        w_sub_d     = 1'b1;
        w_aload_d   = 1'b1;
      end
      StIn: begin
        w_asel_d  = 2'b01;
        w_aload_d = IN_HSHAKE ? w_edge_next : 1'b1;
      end
      StJz:   w_pcload_d = i_aeq0;
      StJpos: w_pcload_d = i_apos;
      StHalt: w_halt_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StStart;
      r_cnt      <= '0;
      r_enter_s1 <= 1'b0;
      r_enter_s2 <= 1'b0;
      r_enter_s3 <= 1'b0;
      r_irload   <= 1'b0;
      r_jmpmux   <= 1'b0;
      r_pcload   <= 1'b0;
      r_meminst  <= 1'b0;
      r_memwr    <= 1'b0;
      r_aload    <= 1'b0;
      r_sub      <= 1'b0;
      r_asel     <= 2'b00;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_enter_s1 <= i_enter;
      r_enter_s2 <= r_enter_s1;
      r_enter_s3 <= r_enter_s2;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_irload   <= w_irload_d;
      r_jmpmux   <= w_jmpmux_d;
      r_pcload   <= w_pcload_d;
      r_meminst  <= w_meminst_d;
      r_memwr    <= w_memwr_d;
      r_aload    <= w_aload_d;
      r_sub      <= w_sub_d;
      r_asel     <= w_asel_d;
      r_halt     <= w_halt_d;
    end
  end

  assign o_irload    = r_irload;
  assign o_jmpmux    = r_jmpmux;
  assign o_pcload    = r_pcload;
  assign o_meminst   = r_meminst;
  assign o_memwr     = r_memwr;
  assign o_aload     = r_aload;
  assign o_sub       = r_sub;
  assign o_asel      = r_asel;
  assign o_halt      = r_halt;
  assign o_state     = r_state;
  assign o_instr_cnt = r_cnt;

endmodule
